quad_angle_tracker: RTL

//  Parametrised quadrature angle tracker for the motor hall-sensor pair.
//  - Synchronises and deglitches both hall inputs.
//  - Decodes direction from the phase sequence itself; no external direction hint is used.
//  - Maintains a wrapping shaft angle and a step-period measurement.
//  - Flags illegal transitions.

---
 rtl/quad_pkg.sv | 50 +++++
 rtl/quad_angle_tracker_if.sv | 27 ++
 rtl/quad_input_filter.sv | 61 ++++++
 rtl/quad_angle_tracker.sv | 117 +++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and transition helpers for the quadrature angle tracker.
// State codes are {A,B}; clockwise order is 00 -> 10 -> 11 -> 01 -> 00.
package quad_pkg;

  typedef enum logic [1:0] {Q_NONE, Q_CW, Q_CCW, Q_ILLEGAL} qstep_t;

  function automatic logic [1:0] next_cw(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      2'b00:   n = 2'b10;
      2'b10:   n = 2'b11;
      2'b11:   n = 2'b01;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  function automatic qstep_t classify(input logic [1:0] s_prev, input logic [1:0] s);
    logic [1:0] diff;
    qstep_t     k;
    diff = s_prev ^ s;
    if (diff == 2'b00)
      k = Q_NONE;
    else if (diff == 2'b11)
      k = Q_ILLEGAL;
    else if (next_cw(s_prev) == s)
      k = Q_CW;
    else
      k = Q_CCW;
    return k;
  endfunction

  // x2 counts edges of B only; x1 counts only the 10<->11 pair.
  function automatic bit counts(input logic [1:0] s_prev, input logic [1:0] s,
                                input int decode_x);
    qstep_t k;
    bit     c;
    k = classify(s_prev, s);
    if (k != Q_CW && k != Q_CCW)
      c = 1'b0;
    else if (decode_x == 4)
      c = 1'b1;
    else if (decode_x == 2)
      c = (s_prev[0] != s[0]);
    else
      c = ({s_prev, s} == 4'b1011) || ({s_prev, s} == 4'b1110);
    return c;
  endfunction

endpackage

// File: rtl/quad_angle_tracker_if.sv
// Hall inputs, control pulses and tracker outputs bundled as one bus.
interface quad_angle_tracker_if #(
  parameter int ANGLE_W  = 12,
  parameter int PERIOD_W = 20
);
  logic                hall_a;
  logic                hall_b;
  logic                enable;
  logic                zero_req;
  logic                err_clr;
  logic [ANGLE_W-1:0]  angle;
  logic                dir_cw;
  logic                step;
  logic [PERIOD_W-1:0] period;
  logic                moving;
  logic                err_illegal;

  modport master (
    output hall_a, hall_b, enable, zero_req, err_clr,
    input  angle, dir_cw, step, period, moving, err_illegal
  );

  modport slave (
    input  hall_a, hall_b, enable, zero_req, err_clr,
    output angle, dir_cw, step, period, moving, err_illegal
  );
endinterface

// File: rtl/quad_input_filter.sv
// Two-flop synchroniser followed by a FILTER_LEN-sample stability filter.
// o_valid rises once the pipeline has seen enough samples to trust o_level.
module quad_input_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic n_reset,
  input  logic i_pin,
  output logic o_level,
  output logic o_valid
);

  localparam int CNT_W  = $clog2(FILTER_LEN + 1);
  localparam int WARM   = FILTER_LEN + 2;
  localparam int WARM_W = $clog2(WARM + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FILTER_LEN - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARM - 1);

  logic [1:0]        r_sync;
  logic              r_level;
  logic [CNT_W-1:0]  r_cnt;
  logic [WARM_W-1:0] r_warm;
  logic              r_valid;

  // A differing sample run must last FILTER_LEN samples before the level flips.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_sync  <= 2'b00;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_pin};
      if (r_sync[1] != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync[1];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_warm  <= '0;
      r_valid <= 1'b0;
    end else if (!r_valid) begin
      if (r_warm == WARM_LAST)
        r_valid <= 1'b1;
      else
        r_warm <= r_warm + 1'b1;
    end
  end

  assign o_level = r_level;
  assign o_valid = r_valid;

endmodule

// File: rtl/quad_angle_tracker.sv
// Quadrature hall-pair decoder: wrapping shaft angle, step period, illegal-jump flag.
// Direction comes purely from the filtered {A,B} sequence.
module quad_angle_tracker
  import quad_pkg::*;
#(
  parameter int ANGLE_W        = 12,
  parameter int COUNTS_PER_REV = 1008,
  parameter int DECODE_X       = 4,
  parameter int FILTER_LEN     = 4,
  parameter int PERIOD_W       = 20
) (
  input logic                 clk,
  input logic                 n_reset,
  quad_angle_tracker_if.slave bus
);

  localparam logic [ANGLE_W-1:0]  ANGLE_MAX  = ANGLE_W'(COUNTS_PER_REV - 1);
  localparam logic [PERIOD_W-1:0] PERIOD_SAT = '1;

  logic w_a, w_b, w_valid_a, w_valid_b;
  logic [1:0] w_s;
  qstep_t     w_kind;
  logic       w_counted;

  logic [1:0]          r_s_prev;
  logic                r_primed;
  logic [ANGLE_W-1:0]  r_angle;
  logic                r_dir_cw;
  logic                r_step;
  logic [PERIOD_W-1:0] r_live;
  logic [PERIOD_W-1:0] r_period;
  logic                r_moving;
  logic                r_err;

  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .n_reset(n_reset), .i_pin(bus.hall_a), .o_level(w_a), .o_valid(w_valid_a)
  );

  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .n_reset(n_reset), .i_pin(bus.hall_b), .o_level(w_b), .o_valid(w_valid_b)
  );

  always_comb begin
    w_s       = {w_a, w_b};
    w_kind    = classify(r_s_prev, w_s);
    w_counted = r_primed && counts(r_s_prev, w_s, DECODE_X);
  end

  // The first trusted sample only seeds s_prev, so power-up never counts.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_primed <= 1'b0;
      r_s_prev <= 2'b00;
      r_dir_cw <= 1'b0;
      r_step   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_step <= w_counted;
      if (!r_primed) begin
        if (w_valid_a && w_valid_b) begin
          r_primed <= 1'b1;
          r_s_prev <= w_s;
        end
      end else if (w_kind != Q_NONE) begin
        r_s_prev <= w_s;
        if (w_kind == Q_CW)
          r_dir_cw <= 1'b1;
        else if (w_kind == Q_CCW)
          r_dir_cw <= 1'b0;
      end
      if (r_primed && w_kind == Q_ILLEGAL)
        r_err <= 1'b1;
      else if (bus.err_clr)
        r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_angle <= '0;
    end else if (bus.zero_req) begin
      r_angle <= '0;
    end else if (w_counted && bus.enable) begin
      if (w_kind == Q_CW)
        r_angle <= (r_angle == ANGLE_MAX) ? '0 : r_angle + 1'b1;
      else
        r_angle <= (r_angle == '0) ? ANGLE_MAX : r_angle - 1'b1;
    end
  end

  // Saturation is detected on the increment, so moving drops as live hits all-ones.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_live   <= '0;
      r_period <= PERIOD_SAT;
      r_moving <= 1'b0;
    end else if (w_counted) begin
      r_period <= (r_live == PERIOD_SAT) ? PERIOD_SAT : r_live + 1'b1;
      r_live   <= '0;
      r_moving <= 1'b1;
    end else if (r_live != PERIOD_SAT) begin
      r_live <= r_live + 1'b1;
      if (r_live == PERIOD_SAT - 1'b1) begin
        r_moving <= 1'b0;
        r_period <= PERIOD_SAT;
      end
    end
  end

  assign bus.angle       = r_angle;
  assign bus.dir_cw      = r_dir_cw;
  assign bus.step        = r_step;
  assign bus.period      = r_period;
  assign bus.moving      = r_moving;
  assign bus.err_illegal = r_err;

endmodule
